xc_wb_queue: RTL and testbench
==============================

XC_WB_QUEUE -- requirements
Module: xc_wb_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 64: result width.
REQ-002 SHALL have parameter IDX_W, default 6: destination register index width.
REQ-003 SHALL have parameter NUM_IN, default 4: ALU input channels, range 1..8.
REQ-004 SHALL have parameter NUM_OUT, default 2: register-file write ports, range 1..NUM_IN.
REQ-005 SHALL have parameter DEPTH, default 8: entries; power of two, >= NUM_IN+NUM_OUT.
REQ-006 SHALL use one clock and a synchronous, active-high reset (ports clock, reset; polarity and synchronicity fixed).
REQ-007 SHALL have ports, clock and reset first:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- X_alu_result_in  in  NUM_IN*DATA_W  channel k result at [k*DATA_W +: DATA_W]
- X_valid_inst_in  in  NUM_IN  per-channel valid
- X_dest_reg_idx_in  in  NUM_IN*IDX_W  per-channel destination index
- X_C_reg_wr_data_out  out  NUM_OUT*DATA_W  write data, port j at [j*DATA_W +: DATA_W]
- X_C_reg_wr_idx_out  out  NUM_OUT*IDX_W  write index
- X_C_reg_wr_en_out  out  NUM_OUT  write enable
- X_C_stall_out  out  1  upstream must not issue
- X_C_count_out  out  log2(DEPTH)+1  current occupancy
- X_C_overflow_out  out  1  sticky overflow error

Function
REQ-008 Channel k SHALL be writeback-enabled iff valid[k]=1 and its index != `ZERO_REG; disabled channels are never stored or written.
REQ-009 Enabled channels SHALL be enqueued in one cycle, in ascending channel order, at tail, tail+1, ... (mod DEPTH).
REQ-010 Storage, head, tail (log2(DEPTH)+1 bits, wrap bit included) and count SHALL be registered; count = tail - head.
REQ-011 Each cycle, D = min(count, NUM_OUT) entries SHALL drain from head: port j presents entry head+j for j<D, oldest on port 0.
REQ-012 Ports j>=D SHALL drive wr_en=0, data=0, idx=0.
REQ-013 Outputs SHALL be combinational from registered state only (no input-to-output path unless XC_BYPASS_EN).
REQ-014 Minimum latency, input to wr_en, SHALL be 1 cycle without bypass; ordering SHALL be FIFO across cycles.
REQ-015 Simultaneous enqueue and drain SHALL be supported: next count = count - D + E, E = enqueued count.
REQ-016 X_C_stall_out SHALL equal (DEPTH - count) < NUM_IN, computed from registered count.
REQ-017 If enabled inputs exceed DEPTH - count + D, the highest-numbered excess channels SHALL be dropped, the rest enqueued, and X_C_overflow_out set, held until reset.
REQ-018 Head and tail wrap-around past DEPTH-1 SHALL be seamless, with no lost or duplicated entries.
REQ-019 Empty (count=0): all wr_en=0. Full (count=DEPTH): stall=1, drain continues.

Reset
REQ-020 On reset: head=tail=0, count=0, all wr_en/data/idx outputs 0, stall=0, overflow=0, all entries index `ZERO_REG with data 0.
REQ-021 Reset SHALL take priority over simultaneous inputs; in-flight entries are discarded and nothing drains in the reset cycle.

Configuration
REQ-022 Macro XC_BYPASS_EN: when defined and count=0, the first min(E, NUM_OUT) enabled inputs SHALL drive ports 0.. in the same cycle (0-cycle latency), and only the remainder is enqueued.
REQ-023 Without XC_BYPASS_EN, all enabled inputs SHALL be enqueued and REQ-013/REQ-014 apply.
REQ-024 Bypass SHALL never reorder: with count>0, inputs always enqueue behind existing entries.

Verification
REQ-025 Defaults, no bypass. Cycle 0: ch0 valid idx 5 data 0xA, ch2 valid idx 31 (`ZERO_REG), ch3 valid idx 7 data 0xB -> cycle 1: port0 (5,0xA), port1 (7,0xB); count 2 -> 0 at cycle 2.
REQ-026 Four valid non-zero inputs for 2 consecutive cycles -> count 4, then 6; stall=1 when count>4; drain 2/cycle in channel order.
REQ-027 Fill to count=8 and present 4 valid inputs with stall=1 -> 2 accepted (drain D=2), ch2/ch3 dropped, overflow=1 persists until reset.
REQ-028 Run 20 single-entry cycles with head starting at 6 -> wrap-around, outputs strictly in input order.
REQ-029 Reset asserted with count=5 -> next cycle count 0, all wr_en 0, overflow 0.
REQ-030 XC_BYPASS_EN, empty queue, 3 valid inputs (ch0, ch1, ch2) -> same cycle ports carry ch0 and ch1; next cycle port0 carries ch2.

Source files
------------

// File: rtl/xc_wb_queue.sv
// Writeback queue: merges up to NUM_IN ALU results per cycle onto NUM_OUT register-file write ports in FIFO order.
// Latency: 1 cycle input to wr_en; 0 cycles from an empty queue when XC_BYPASS_EN is defined.
// Backpressure: stall when free slots < NUM_IN; excess channels are dropped (highest first) and flag a sticky overflow.
`ifndef ZERO_REG
`define ZERO_REG 31
`endif

module xc_wb_queue #(
    parameter int DATA_W  = 64,
    parameter int IDX_W   = 6,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int DEPTH   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_IN*DATA_W-1:0]  X_alu_result_in,
    input  logic [NUM_IN-1:0]         X_valid_inst_in,
    input  logic [NUM_IN*IDX_W-1:0]   X_dest_reg_idx_in,
    output logic [NUM_OUT*DATA_W-1:0] X_C_reg_wr_data_out,
    output logic [NUM_OUT*IDX_W-1:0]  X_C_reg_wr_idx_out,
    output logic [NUM_OUT-1:0]        X_C_reg_wr_en_out,
    output logic                      X_C_stall_out,
    output logic [$clog2(DEPTH):0]    X_C_count_out,
    output logic                      X_C_overflow_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = PW + 1;
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(`ZERO_REG);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [IDX_W-1:0]  mem_idx  [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     count;
    logic              overflow;

    logic [CW-1:0]     count_w;
    logic [CW-1:0]     drain_n;
    logic [CW-1:0]     space;
    logic [CW-1:0]     acc_n;
    logic [NUM_IN-1:0] ch_en;
    logic [NUM_IN-1:0] enq_vld;
    logic [AW-1:0]     enq_off [NUM_IN];
    logic              drop;

    logic [NUM_OUT-1:0] byp_vld;
    logic [DATA_W-1:0]  byp_data [NUM_OUT];
    logic [IDX_W-1:0]   byp_idx  [NUM_OUT];
    logic [AW-1:0]      rd_addr  [NUM_OUT];
`ifdef XC_BYPASS_EN
    logic [CW-1:0]      byp_n;
`endif

    assign count   = tail - head;
    assign count_w = {1'b0, count};
    assign drain_n = (count_w < CW'(NUM_OUT)) ? count_w : CW'(NUM_OUT);
    // Slots freed by this cycle's drain are reusable by this cycle's enqueue.
    assign space   = CW'(DEPTH) - count_w + drain_n;

    always_comb begin : enq_alloc
        acc_n   = '0;
        drop    = 1'b0;
        ch_en   = '0;
        enq_vld = '0;
        byp_vld = '0;
`ifdef XC_BYPASS_EN
        byp_n   = '0;
`endif
        for (int j = 0; j < NUM_OUT; j++) begin
            byp_data[j] = '0;
            byp_idx[j]  = '0;
        end
        for (int k = 0; k < NUM_IN; k++) begin
            enq_off[k] = '0;
        end
        for (int k = 0; k < NUM_IN; k++) begin
            ch_en[k] = X_valid_inst_in[k] && (X_dest_reg_idx_in[k*IDX_W +: IDX_W] != ZERO_IDX);
            if (ch_en[k]) begin
`ifdef XC_BYPASS_EN
                if ((count_w == '0) && (byp_n < CW'(NUM_OUT))) begin
                    for (int j = 0; j < NUM_OUT; j++) begin
                        if (byp_n == CW'(j)) begin
                            byp_vld[j]  = 1'b1;
                            byp_data[j] = X_alu_result_in[k*DATA_W +: DATA_W];
                            byp_idx[j]  = X_dest_reg_idx_in[k*IDX_W +: IDX_W];
                        end
                    end
                    byp_n = byp_n + CW'(1);
                end else
`endif
                if (acc_n < space) begin
                    enq_vld[k] = 1'b1;
                    enq_off[k] = acc_n[AW-1:0];
                    acc_n      = acc_n + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // Ports are gated by reset so nothing is written back in the reset cycle.
    always_comb begin : drain_mux
        X_C_reg_wr_data_out = '0;
        X_C_reg_wr_idx_out  = '0;
        X_C_reg_wr_en_out   = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            rd_addr[j] = head[AW-1:0] + AW'(j);
            if (!reset) begin
                if (CW'(j) < drain_n) begin
                    X_C_reg_wr_en_out[j]                  = 1'b1;
                    X_C_reg_wr_data_out[j*DATA_W +: DATA_W] = mem_data[rd_addr[j]];
                    X_C_reg_wr_idx_out[j*IDX_W +: IDX_W]    = mem_idx[rd_addr[j]];
                end else if (byp_vld[j]) begin
                    X_C_reg_wr_en_out[j]                  = 1'b1;
                    X_C_reg_wr_data_out[j*DATA_W +: DATA_W] = byp_data[j];
                    X_C_reg_wr_idx_out[j*IDX_W +: IDX_W]    = byp_idx[j];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= ZERO_IDX;
            end
        end else begin
            head <= head + drain_n[PW-1:0];
            tail <= tail + acc_n[PW-1:0];
            if (drop) begin
                overflow <= 1'b1;
            end
            for (int k = 0; k < NUM_IN; k++) begin
                if (enq_vld[k]) begin
                    mem_data[tail[AW-1:0] + enq_off[k]] <= X_alu_result_in[k*DATA_W +: DATA_W];
                    mem_idx[tail[AW-1:0] + enq_off[k]]  <= X_dest_reg_idx_in[k*IDX_W +: IDX_W];
                end
            end
        end
    end

    assign X_C_stall_out    = (CW'(DEPTH) - count_w) < CW'(NUM_IN);
    assign X_C_count_out    = count;
    assign X_C_overflow_out = overflow;

endmodule

// File: tb/tb_xc_wb_queue.sv
// Directed bench for xc_wb_queue at default parameters; the bypass build runs its own short sequence.
`ifndef ZERO_REG
`define ZERO_REG 31
`endif

module tb_xc_wb_queue;

    localparam int DW = 64;
    localparam int IW = 6;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int DP = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NI*DW-1:0] alu;
    logic [NI-1:0]    vld;
    logic [NI*IW-1:0] idx_in;
    logic [NO*DW-1:0] wr_data;
    logic [NO*IW-1:0] wr_idx;
    logic [NO-1:0]    wr_en;
    logic             stall;
    logic [3:0]       count;
    logic             overflow;

    int n_cmp = 0;
    int n_err = 0;

    xc_wb_queue #(.DATA_W(DW), .IDX_W(IW), .NUM_IN(NI), .NUM_OUT(NO), .DEPTH(DP)) dut (
        .clock               (clock),
        .reset               (reset),
        .X_alu_result_in     (alu),
        .X_valid_inst_in     (vld),
        .X_dest_reg_idx_in   (idx_in),
        .X_C_reg_wr_data_out (wr_data),
        .X_C_reg_wr_idx_out  (wr_idx),
        .X_C_reg_wr_en_out   (wr_en),
        .X_C_stall_out       (stall),
        .X_C_count_out       (count),
        .X_C_overflow_out    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_port(input string tag, input int j, input logic en,
                            input logic [IW-1:0] idx, input logic [DW-1:0] data);
        check({tag, "_en"}, 64'(wr_en[j]), 64'(en));
        check({tag, "_idx"}, 64'(wr_idx[j*IW +: IW]), en ? 64'(idx) : 64'd0);
        check({tag, "_dat"}, wr_data[j*DW +: DW], en ? data : 64'd0);
    endtask

    task automatic clr();
        vld    = '0;
        idx_in = '0;
        alu    = '0;
    endtask

    task automatic set_ch(input int k, input logic [IW-1:0] idx, input logic [DW-1:0] d);
        vld[k]             = 1'b1;
        idx_in[k*IW +: IW] = idx;
        alu[k*DW +: DW]    = d;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_dat", wr_data, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

`ifdef XC_BYPASS_EN
        // empty queue: ch0/ch1 go straight out, ch2 queued
        set_ch(0, 6'd1, 64'hA1);
        set_ch(1, 6'd2, 64'hA2);
        set_ch(2, 6'd3, 64'hA3);
        #1;
        chk_port("byp_p0", 0, 1'b1, 6'd1, 64'hA1);
        chk_port("byp_p1", 1, 1'b1, 6'd2, 64'hA2);
        check("byp_count0", 64'(count), 64'd0);
        cyc();
        clr();
        set_ch(0, 6'd4, 64'hB4);
        set_ch(1, 6'd5, 64'hB5);
        set_ch(2, 6'd6, 64'hB6);
        set_ch(3, 6'd7, 64'hB7);
        #1;
        chk_port("byp_next_p0", 0, 1'b1, 6'd3, 64'hA3);
        chk_port("byp_next_p1", 1, 1'b0, 6'd0, 64'd0);
        check("byp_count1", 64'(count), 64'd1);
        cyc();
        clr();
        check("byp_count4", 64'(count), 64'd4);
        chk_port("byp_ord_p0", 0, 1'b1, 6'd4, 64'hB4);
        chk_port("byp_ord_p1", 1, 1'b1, 6'd5, 64'hB5);
        cyc();
        chk_port("byp_ord2_p0", 0, 1'b1, 6'd6, 64'hB6);
        chk_port("byp_ord2_p1", 1, 1'b1, 6'd7, 64'hB7);
        cyc();
        check("byp_empty", 64'(count), 64'd0);
`else
        // ch2 targets the zero register, ch1 is not valid
        set_ch(0, 6'd5, 64'hA);
        set_ch(2, 6'd`ZERO_REG, 64'hC);
        set_ch(3, 6'd7, 64'hB);
        idx_in[1*IW +: IW] = 6'd9;
        alu[1*DW +: DW]    = 64'hD;
        #1;
        check("t1_no_comb_path", 64'(wr_en), 64'd0);
        cyc();
        clr();
        #1;
        check("t1_count", 64'(count), 64'd2);
        chk_port("t1_p0", 0, 1'b1, 6'd5, 64'hA);
        chk_port("t1_p1", 1, 1'b1, 6'd7, 64'hB);
        cyc();
        check("t1_count_end", 64'(count), 64'd0);
        check("t1_wr_en_end", 64'(wr_en), 64'd0);

        // two bursts of four
        for (int k = 0; k < 4; k++) set_ch(k, 6'(k + 1), 64'(8'h11 + k));
        #1;
        check("t2_stall0", 64'(stall), 64'd0);
        cyc();
        check("t2_count4", 64'(count), 64'd4);
        check("t2_stall4", 64'(stall), 64'd0);
        chk_port("t2a_p0", 0, 1'b1, 6'd1, 64'h11);
        chk_port("t2a_p1", 1, 1'b1, 6'd2, 64'h12);
        clr();
        for (int k = 0; k < 4; k++) set_ch(k, 6'(k + 10), 64'(8'h21 + k));
        cyc();
        clr();
        check("t2_count6", 64'(count), 64'd6);
        check("t2_stall6", 64'(stall), 64'd1);
        chk_port("t2b_p0", 0, 1'b1, 6'd3, 64'h13);
        chk_port("t2b_p1", 1, 1'b1, 6'd4, 64'h14);
        cyc();
        check("t2_count4b", 64'(count), 64'd4);
        check("t2_stall4b", 64'(stall), 64'd0);
        chk_port("t2c_p0", 0, 1'b1, 6'd10, 64'h21);
        chk_port("t2c_p1", 1, 1'b1, 6'd11, 64'h22);
        cyc();
        chk_port("t2d_p0", 0, 1'b1, 6'd12, 64'h23);
        chk_port("t2d_p1", 1, 1'b1, 6'd13, 64'h24);
        cyc();
        check("t2_empty", 64'(count), 64'd0);

        // fill to full, then overflow while draining two
        for (int c = 0; c < 3; c++) begin
            clr();
            for (int k = 0; k < 4; k++) set_ch(k, 6'(8'h31 + 8'h10 * c + k), 64'(8'h31 + 8'h10 * c + k));
            cyc();
        end
        check("t3_full_count", 64'(count), 64'd8);
        check("t3_full_stall", 64'(stall), 64'd1);
        check("t3_full_ovf", 64'(overflow), 64'd0);
        chk_port("t3_full_p0", 0, 1'b1, 6'h01, 64'h41);
        chk_port("t3_full_p1", 1, 1'b1, 6'h02, 64'h42);
        clr();
        for (int k = 0; k < 4; k++) set_ch(k, 6'(8'h61 + k), 64'(8'h61 + k));
        cyc();
        clr();
        check("t3_ovf_count", 64'(count), 64'd8);
        check("t3_ovf_set", 64'(overflow), 64'd1);
        chk_port("t3_d0_p0", 0, 1'b1, 6'h03, 64'h43);
        chk_port("t3_d0_p1", 1, 1'b1, 6'h04, 64'h44);
        cyc();
        check("t3_count6", 64'(count), 64'd6);
        chk_port("t3_d1_p0", 0, 1'b1, 6'h11, 64'h51);
        chk_port("t3_d1_p1", 1, 1'b1, 6'h12, 64'h52);
        cyc();
        chk_port("t3_d2_p0", 0, 1'b1, 6'h13, 64'h53);
        chk_port("t3_d2_p1", 1, 1'b1, 6'h14, 64'h54);
        cyc();
        chk_port("t3_d3_p0", 0, 1'b1, 6'h21, 64'h61);
        chk_port("t3_d3_p1", 1, 1'b1, 6'h22, 64'h62);
        cyc();
        check("t3_drained", 64'(count), 64'd0);
        check("t3_wr_en_off", 64'(wr_en), 64'd0);
        cyc();
        check("t3_ovf_sticky", 64'(overflow), 64'd1);

        // reset with five queued entries and live inputs
        for (int k = 0; k < 4; k++) set_ch(k, 6'(k + 1), 64'(8'h71 + k));
        cyc();
        clr();
        for (int k = 0; k < 3; k++) set_ch(k, 6'(k + 5), 64'(8'h81 + k));
        cyc();
        check("t5_count5", 64'(count), 64'd5);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) set_ch(k, 6'(k + 1), 64'(8'h91 + k));
        #1;
        check("t5_no_drain_in_rst", 64'(wr_en), 64'd0);
        cyc();
        reset = 1'b0;
        clr();
        #1;
        check("t5_count0", 64'(count), 64'd0);
        check("t5_wr_en0", 64'(wr_en), 64'd0);
        check("t5_ovf0", 64'(overflow), 64'd0);
        check("t5_stall0", 64'(stall), 64'd0);
        cyc();
        check("t5_inputs_discarded", 64'(count), 64'd0);

        // single entries across several pointer wraps
        for (int i = 0; i < 26; i++) begin
            clr();
            set_ch(i % 4, 6'((i % 30) + 1), 64'(16'h100 + i));
            #1;
            if (i == 0) begin
                check("t4_first_en", 64'(wr_en), 64'd0);
            end else begin
                chk_port("t4_p0", 0, 1'b1, 6'(((i - 1) % 30) + 1), 64'(16'h100 + i - 1));
                check("t4_p1_en", 64'(wr_en[1]), 64'd0);
                check("t4_count", 64'(count), 64'd1);
            end
            cyc();
        end
        clr();
        #1;
        chk_port("t4_last", 0, 1'b1, 6'((25 % 30) + 1), 64'(16'h100 + 25));
        cyc();
        check("t4_empty", 64'(count), 64'd0);
        check("t4_ovf", 64'(overflow), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
